// File: rtl/id_ex_stage_if.sv
// Handshake and datapath bundle between decode, register file, forwarding
// sources and the ID/EX register of the RiSC-16 pipeline.
interface id_ex_stage_if #(parameter int p_WORD_LEN = 16);
    logic                  i_valid;
    logic                  o_ready;
    logic [p_WORD_LEN-1:0] i_instr;
    logic [p_WORD_LEN-1:0] i_pc;
    logic [2:0]            o_rs1;
    logic [2:0]            o_rs2;
    logic [p_WORD_LEN-1:0] i_rs1_data;
    logic [p_WORD_LEN-1:0] i_rs2_data;
    logic [p_WORD_LEN-1:0] i_ex_result;
    logic                  i_mem_wr_en;
    logic [2:0]            i_mem_rd;
    logic [p_WORD_LEN-1:0] i_mem_data;
    logic                  i_wb_wr_en;
    logic [2:0]            i_wb_rd;
    logic [p_WORD_LEN-1:0] i_wb_data;
    logic                  i_flush;
    logic                  o_valid;
    logic                  o_alu_op;
    logic [p_WORD_LEN-1:0] o_alu_a;
    logic [p_WORD_LEN-1:0] o_alu_b;
    logic [p_WORD_LEN-1:0] o_aux;
    logic [2:0]            o_rd;
    logic                  o_wr_en;
    logic                  o_is_load;
    logic                  o_is_store;
    logic                  o_is_beq;
    logic                  o_is_jalr;
    logic [p_WORD_LEN-1:0] o_pc;

    modport master (
        output i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ex_result,
               i_mem_wr_en, i_mem_rd, i_mem_data, i_wb_wr_en, i_wb_rd, i_wb_data, i_flush,
        input  o_ready, o_rs1, o_rs2, o_valid, o_alu_op, o_alu_a, o_alu_b, o_aux,
               o_rd, o_wr_en, o_is_load, o_is_store, o_is_beq, o_is_jalr, o_pc
    );

    modport slave (
        input  i_valid, i_instr, i_pc, i_rs1_data, i_rs2_data, i_ex_result,
               i_mem_wr_en, i_mem_rd, i_mem_data, i_wb_wr_en, i_wb_rd, i_wb_data, i_flush,
        output o_ready, o_rs1, o_rs2, o_valid, o_alu_op, o_alu_a, o_alu_b, o_aux,
               o_rd, o_wr_en, o_is_load, o_is_store, o_is_beq, o_is_jalr, o_pc
    );
endinterface

// File: rtl/id_ex_stage.sv
// RiSC-16 decode-to-execute stage: decode, operand forwarding, load-use
// stall detection and the ID/EX pipeline register.
module id_ex_stage #(
    parameter int p_WORD_LEN = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    id_ex_stage_if.slave  bus
);
    typedef logic [p_WORD_LEN-1:0] word_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam word_t ZERO_W = {p_WORD_LEN{1'b0}};
    localparam word_t ONE_W  = {{(p_WORD_LEN-1){1'b0}}, 1'b1};

    // Forwarding priority: r0, then EX, then MEM, then WB, then register file.
    function automatic word_t resolve(
        input logic [2:0] idx, input word_t rf_data,
        input logic ex_en, input logic [2:0] ex_rd, input word_t ex_data,
        input logic mem_en, input logic [2:0] mem_rd, input word_t mem_data,
        input logic wb_en, input logic [2:0] wb_rd, input word_t wb_data);
        word_t r;
        if (idx == 3'd0)                      r = ZERO_W;
        else if (ex_en && (ex_rd == idx))     r = ex_data;
        else if (mem_en && (mem_rd == idx))   r = mem_data;
        else if (wb_en && (wb_rd == idx))     r = wb_data;
        else                                  r = rf_data;
        return r;
    endfunction

    logic       valid_r, alu_op_r, wr_en_r, is_load_r, is_store_r, is_beq_r, is_jalr_r;
    word_t      alu_a_r, alu_b_r, aux_r, pc_r;
    logic [2:0] rd_r;

    logic [2:0] opcode_s, ra_s, rb_s, rc_s, rs1_s, rs2_s;
    word_t      simm_s, op1_s, op2_s;
    logic       ex_fwd_en_s, hazard_s;

    word_t      d_a_s, d_b_s, d_aux_s;
    logic       d_op_s, d_writes_s, d_load_s, d_store_s, d_beq_s, d_jalr_s;
    logic [2:0] d_rd_s;

    assign opcode_s = bus.i_instr[15:13];
    assign ra_s     = bus.i_instr[12:10];
    assign rb_s     = bus.i_instr[9:7];
    assign rc_s     = bus.i_instr[2:0];
    assign simm_s   = {{(p_WORD_LEN-7){bus.i_instr[6]}}, bus.i_instr[6:0]};

    // Source register selection; unused sources read index 0.
    always_comb begin
        rs1_s = 3'd0;
        rs2_s = 3'd0;
        case (opcode_s)
            OP_ADD, OP_NAND: begin rs1_s = rb_s; rs2_s = rc_s; end
            OP_ADDI, OP_LW, OP_JALR: rs1_s = rb_s;
            OP_SW:           begin rs1_s = rb_s; rs2_s = ra_s; end
            OP_BEQ:          begin rs1_s = ra_s; rs2_s = rb_s; end
            default:         begin rs1_s = 3'd0; rs2_s = 3'd0; end
        endcase
    end

    // A load in EX has no result yet, so it is never an EX forwarding source.
    assign ex_fwd_en_s = valid_r && wr_en_r && !is_load_r;

    assign op1_s = resolve(rs1_s, bus.i_rs1_data, ex_fwd_en_s, rd_r, bus.i_ex_result,
                           bus.i_mem_wr_en, bus.i_mem_rd, bus.i_mem_data,
                           bus.i_wb_wr_en, bus.i_wb_rd, bus.i_wb_data);
    assign op2_s = resolve(rs2_s, bus.i_rs2_data, ex_fwd_en_s, rd_r, bus.i_ex_result,
                           bus.i_mem_wr_en, bus.i_mem_rd, bus.i_mem_data,
                           bus.i_wb_wr_en, bus.i_wb_rd, bus.i_wb_data);

    assign hazard_s = bus.i_valid && valid_r && is_load_r && wr_en_r &&
                      (((rs1_s != 3'd0) && (rd_r == rs1_s)) ||
                       ((rs2_s != 3'd0) && (rd_r == rs2_s)));

    // Execute-stage operands and control for the instruction in decode.
    always_comb begin
        d_op_s = 1'b0; d_a_s = ZERO_W; d_b_s = ZERO_W; d_aux_s = ZERO_W;
        d_writes_s = 1'b0; d_load_s = 1'b0; d_store_s = 1'b0;
        d_beq_s = 1'b0; d_jalr_s = 1'b0;
        case (opcode_s)
            OP_ADD:  begin d_a_s = op1_s; d_b_s = op2_s; d_writes_s = 1'b1; end
            OP_NAND: begin d_a_s = op1_s; d_b_s = op2_s; d_op_s = 1'b1; d_writes_s = 1'b1; end
            OP_ADDI: begin d_a_s = op1_s; d_b_s = simm_s; d_writes_s = 1'b1; end
            OP_LUI:  begin d_a_s = {bus.i_instr[9:0], 6'b000000}; d_writes_s = 1'b1; end
            OP_SW:   begin d_a_s = op1_s; d_b_s = simm_s; d_aux_s = op2_s; d_store_s = 1'b1; end
            OP_LW:   begin d_a_s = op1_s; d_b_s = simm_s; d_load_s = 1'b1; d_writes_s = 1'b1; end
            OP_BEQ:  begin
                d_a_s = op1_s; d_b_s = op2_s; d_beq_s = 1'b1;
                d_aux_s = bus.i_pc + ONE_W + simm_s;
            end
            OP_JALR: begin
                d_a_s = bus.i_pc; d_b_s = ONE_W; d_aux_s = op1_s;
                d_jalr_s = 1'b1; d_writes_s = 1'b1;
            end
            default: begin d_a_s = ZERO_W; d_b_s = ZERO_W; end
        endcase
        d_rd_s = d_writes_s ? ra_s : 3'd0;
    end

    // ID/EX register: reset, flush, stall and idle all load an all-zero bubble.
    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush || hazard_s || !bus.i_valid) begin
            valid_r <= 1'b0; alu_op_r <= 1'b0; alu_a_r <= ZERO_W; alu_b_r <= ZERO_W;
            aux_r <= ZERO_W; rd_r <= 3'd0; wr_en_r <= 1'b0; is_load_r <= 1'b0;
            is_store_r <= 1'b0; is_beq_r <= 1'b0; is_jalr_r <= 1'b0; pc_r <= ZERO_W;
        end else begin
            valid_r <= 1'b1; alu_op_r <= d_op_s; alu_a_r <= d_a_s; alu_b_r <= d_b_s;
            aux_r <= d_aux_s; rd_r <= d_rd_s; wr_en_r <= d_writes_s && (ra_s != 3'd0);
            is_load_r <= d_load_s; is_store_r <= d_store_s; is_beq_r <= d_beq_s;
            is_jalr_r <= d_jalr_s; pc_r <= bus.i_pc;
        end
    end

    assign bus.o_ready    = !hazard_s;
    assign bus.o_rs1      = rs1_s;
    assign bus.o_rs2      = rs2_s;
    assign bus.o_valid    = valid_r;
    assign bus.o_alu_op   = alu_op_r;
    assign bus.o_alu_a    = alu_a_r;
    assign bus.o_alu_b    = alu_b_r;
    assign bus.o_aux      = aux_r;
    assign bus.o_rd       = rd_r;
    assign bus.o_wr_en    = wr_en_r;
    assign bus.o_is_load  = is_load_r;
    assign bus.o_is_store = is_store_r;
    assign bus.o_is_beq   = is_beq_r;
    assign bus.o_is_jalr  = is_jalr_r;
    assign bus.o_pc       = pc_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage: table of hand-computed cycles plus
// short sequences for flush/stall overlap, idle-after-load and mid-run reset.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.p_WORD_LEN(16)) bus ();
    id_ex_stage #(.p_WORD_LEN(16)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    localparam logic [2:0] ADD = 3'b000, ADDI = 3'b001, NAND = 3'b010, LUI = 3'b011;
    localparam logic [2:0] SW = 3'b100, LW = 3'b101, BEQ = 3'b110, JALR = 3'b111;

    typedef struct {
        logic        rst, valid, flush;
        logic [15:0] instr, pc, rf1, rf2, exr;
        logic        mem_en; logic [2:0] mem_rd; logic [15:0] mem_data;
        logic        wb_en;  logic [2:0] wb_rd;  logic [15:0] wb_data;
        logic        e_ready; logic [2:0] e_rs1, e_rs2;
        logic [73:0] e_out;
    } vec_t;

    function automatic logic [15:0] rrr(input logic [2:0] op, ra, rb, rc);
        return {op, ra, rb, 4'b0000, rc};
    endfunction
    function automatic logic [15:0] rri(input logic [2:0] op, ra, rb, input logic [6:0] s7);
        return {op, ra, rb, s7};
    endfunction
    function automatic logic [15:0] lui(input logic [2:0] ra, input logic [9:0] imm);
        return {LUI, ra, imm};
    endfunction

    // Expected output bundle {valid,op,a,b,aux,rd,wr_en,load,store,beq,jalr,pc}
    function automatic logic [73:0] eo(input logic v, op, input logic [15:0] a, b, aux,
                                       input logic [2:0] rd, input logic wr,
                                       input logic [3:0] flags, input logic [15:0] pc);
        return {v, op, a, b, aux, rd, wr, flags, pc};
    endfunction

    function automatic vec_t mk(input logic r, v, f, input logic [15:0] instr, pc, rf1, rf2, exr,
                                input logic me, input logic [2:0] mr, input logic [15:0] md,
                                input logic we, input logic [2:0] wr, input logic [15:0] wd,
                                input logic er, input logic [2:0] e1, e2, input logic [73:0] eout);
        vec_t t;
        t.rst = r; t.valid = v; t.flush = f; t.instr = instr; t.pc = pc;
        t.rf1 = rf1; t.rf2 = rf2; t.exr = exr;
        t.mem_en = me; t.mem_rd = mr; t.mem_data = md;
        t.wb_en = we; t.wb_rd = wr; t.wb_data = wd;
        t.e_ready = er; t.e_rs1 = e1; t.e_rs2 = e2; t.e_out = eout;
        return t;
    endfunction

    task automatic chk(input string nm, input int id, input logic [73:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h want %h", nm, id, act, exp);
        end
    endtask

    function automatic logic [73:0] dut_out();
        return {bus.o_valid, bus.o_alu_op, bus.o_alu_a, bus.o_alu_b, bus.o_aux, bus.o_rd,
                bus.o_wr_en, bus.o_is_load, bus.o_is_store, bus.o_is_beq, bus.o_is_jalr, bus.o_pc};
    endfunction

    // Drive one cycle of inputs just after a rising edge, check the
    // combinational outputs, then check the register after the next edge.
    task automatic apply(input vec_t t, input int id);
        rst = t.rst;
        bus.i_valid = t.valid; bus.i_flush = t.flush;
        bus.i_instr = t.instr; bus.i_pc = t.pc;
        bus.i_rs1_data = t.rf1; bus.i_rs2_data = t.rf2; bus.i_ex_result = t.exr;
        bus.i_mem_wr_en = t.mem_en; bus.i_mem_rd = t.mem_rd; bus.i_mem_data = t.mem_data;
        bus.i_wb_wr_en = t.wb_en; bus.i_wb_rd = t.wb_rd; bus.i_wb_data = t.wb_data;
        #1;
        chk("ready", id, {73'd0, bus.o_ready}, {73'd0, t.e_ready});
        chk("rs1", id, {71'd0, bus.o_rs1}, {71'd0, t.e_rs1});
        chk("rs2", id, {71'd0, bus.o_rs2}, {71'd0, t.e_rs2});
        @(posedge clk);
        #1;
        chk("ex_reg", id, dut_out(), t.e_out);
    endtask

    vec_t vecs[17];

    initial begin
        vecs[0]  = mk(0,1,0, rrr(ADD,1,2,3), 16'h0010, 16'h0005, 16'h0007, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd2,3'd3, eo(1,0,16'h0005,16'h0007,16'h0,1,1,4'b0000,16'h0010));
        vecs[1]  = mk(0,1,0, rri(ADDI,1,0,7'h7F), 16'h0011, 16'h5555, 16'h6666, 16'h000C,
                      0,0,16'h0, 0,0,16'h0, 1,3'd0,3'd0, eo(1,0,16'h0000,16'hFFFF,16'h0,1,1,4'b0000,16'h0011));
        vecs[2]  = mk(0,1,0, rrr(ADD,2,1,1), 16'h0012, 16'h1111, 16'h2222, 16'hFFFF,
                      1,1,16'h0BAD, 0,0,16'h0, 1,3'd1,3'd1, eo(1,0,16'hFFFF,16'hFFFF,16'h0,2,1,4'b0000,16'h0012));
        vecs[3]  = mk(0,1,0, rri(LW,4,1,7'h00), 16'h0013, 16'h1111, 16'h2222, 16'hFFFE,
                      1,1,16'hFFFF, 0,0,16'h0, 1,3'd1,3'd0, eo(1,0,16'hFFFF,16'h0000,16'h0,4,1,4'b1000,16'h0013));
        vecs[4]  = mk(0,1,0, rrr(NAND,5,4,4), 16'h0014, 16'h0000, 16'h0000, 16'h0004,
                      0,0,16'h0, 0,0,16'h0, 0,3'd4,3'd4, 74'd0);
        vecs[5]  = mk(0,1,0, rrr(NAND,5,4,4), 16'h0014, 16'h0000, 16'h0000, 16'h0000,
                      1,4,16'h1234, 0,0,16'h0, 1,3'd4,3'd4, eo(1,1,16'h1234,16'h1234,16'h0,5,1,4'b0000,16'h0014));
        vecs[6]  = mk(0,1,0, rrr(ADD,6,3,0), 16'h0015, 16'h00FF, 16'h7777, 16'h5A5A,
                      1,3,16'h000A, 1,3,16'h000B, 1,3'd3,3'd0, eo(1,0,16'h000A,16'h0000,16'h0,6,1,4'b0000,16'h0015));
        vecs[7]  = mk(0,1,0, rrr(ADD,6,3,2), 16'h0016, 16'h00FF, 16'h0003, 16'h5A5A,
                      0,0,16'h0, 1,3,16'h000B, 1,3'd3,3'd2, eo(1,0,16'h000B,16'h0003,16'h0,6,1,4'b0000,16'h0016));
        vecs[8]  = mk(0,1,0, lui(7,10'h3FF), 16'h0017, 16'h1111, 16'h2222, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd0,3'd0, eo(1,0,16'hFFC0,16'h0000,16'h0,7,1,4'b0000,16'h0017));
        vecs[9]  = mk(0,1,0, rri(BEQ,1,2,7'h00), 16'hFFFF, 16'h0007, 16'h0007, 16'hFFC0,
                      0,0,16'h0, 0,0,16'h0, 1,3'd1,3'd2, eo(1,0,16'h0007,16'h0007,16'h0000,0,0,4'b0010,16'hFFFF));
        vecs[10] = mk(0,1,0, rri(BEQ,3,3,7'h7E), 16'h0040, 16'h0009, 16'h0009, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd3,3'd3, eo(1,0,16'h0009,16'h0009,16'h003F,0,0,4'b0010,16'h0040));
        vecs[11] = mk(0,1,0, rri(SW,5,6,7'h03), 16'h0041, 16'h0100, 16'hABCD, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd6,3'd5, eo(1,0,16'h0100,16'h0003,16'hABCD,0,0,4'b0100,16'h0041));
        vecs[12] = mk(0,1,0, rri(JALR,0,2,7'h00), 16'h0050, 16'h0200, 16'h0000, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd2,3'd0, eo(1,0,16'h0050,16'h0001,16'h0200,0,0,4'b0001,16'h0050));
        vecs[13] = mk(0,1,1, rri(JALR,3,4,7'h00), 16'h0060, 16'h0300, 16'h0000, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd4,3'd0, 74'd0);
        vecs[14] = mk(0,1,0, rri(JALR,3,4,7'h00), 16'h0060, 16'h0300, 16'h0000, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd4,3'd0, eo(1,0,16'h0060,16'h0001,16'h0300,3,1,4'b0001,16'h0060));
        vecs[15] = mk(0,1,0, rrr(ADD,1,3,3), 16'h0061, 16'h0AAA, 16'h0BBB, 16'h0061,
                      0,0,16'h0, 0,0,16'h0, 1,3'd3,3'd3, eo(1,0,16'h0061,16'h0061,16'h0,1,1,4'b0000,16'h0061));
        vecs[16] = mk(0,0,0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                      0,0,16'h0, 0,0,16'h0, 1,3'd0,3'd0, 74'd0);

        apply(mk(1,0,0, 16'h0,16'h0,16'h0,16'h0,16'h0, 0,0,16'h0, 0,0,16'h0, 1,3'd0,3'd0, 74'd0), 100);
        apply(mk(1,0,0, 16'h0,16'h0,16'h0,16'h0,16'h0, 0,0,16'h0, 0,0,16'h0, 1,3'd0,3'd0, 74'd0), 101);

        for (int i = 0; i < 17; i++) apply(vecs[i], i);

        // Load-use stall on rs2 coinciding with a flush, then the retry forwards from MEM.
        apply(mk(0,1,0, rri(LW,2,1,7'h00), 16'h0070, 16'h0008, 16'h0000, 16'h0000,
                 0,0,16'h0, 0,0,16'h0, 1,3'd1,3'd0, eo(1,0,16'h0008,16'h0000,16'h0,2,1,4'b1000,16'h0070)), 200);
        apply(mk(0,1,1, rrr(ADD,3,0,2), 16'h0071, 16'h0000, 16'h0099, 16'h0000,
                 0,0,16'h0, 0,0,16'h0, 0,3'd0,3'd2, 74'd0), 201);
        apply(mk(0,1,0, rrr(ADD,3,0,2), 16'h0071, 16'h0000, 16'h0099, 16'h0000,
                 1,2,16'h0042, 0,0,16'h0, 1,3'd0,3'd2, eo(1,0,16'h0000,16'h0042,16'h0,3,1,4'b0000,16'h0071)), 202);

        // A dependent but invalid decode slot behind a load does not stall.
        apply(mk(0,1,0, rri(LW,4,1,7'h00), 16'h0080, 16'h0020, 16'h0000, 16'h0000,
                 0,0,16'h0, 0,0,16'h0, 1,3'd1,3'd0, eo(1,0,16'h0020,16'h0000,16'h0,4,1,4'b1000,16'h0080)), 300);
        apply(mk(0,0,0, rrr(NAND,5,4,4), 16'h0081, 16'h0000, 16'h0000, 16'h0000,
                 0,0,16'h0, 0,0,16'h0, 1,3'd4,3'd4, 74'd0), 301);

        // Reset mid-run clears the register even with a valid instruction present.
        apply(mk(0,1,0, rrr(ADD,1,2,3), 16'h0090, 16'h0001, 16'h0002, 16'h0000,
                 0,0,16'h0, 0,0,16'h0, 1,3'd2,3'd3, eo(1,0,16'h0001,16'h0002,16'h0,1,1,4'b0000,16'h0090)), 400);
        apply(mk(1,1,0, rrr(ADD,1,2,3), 16'h0091, 16'h0001, 16'h0002, 16'h0000,
                 0,0,16'h0, 0,0,16'h0, 1,3'd2,3'd3, 74'd0), 401);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
